// File: rtl/pipelined_mips32.sv
// pipelined_mips32: five-stage in-order MIPS32-subset core, unified word-addressed memory.
// Define MUL_EN to implement the MUL opcode; without it MUL decodes as a NOP.
module pipelined_mips32 #(
   parameter int MEM_WORDS = 1024
) (
   input  logic clk1,
   input  logic rst,
   output logic halted
);
   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   localparam logic [5:0] op_add   = 6'b000000;
   localparam logic [5:0] op_sub   = 6'b000001;
   localparam logic [5:0] op_and   = 6'b000010;
   localparam logic [5:0] op_or    = 6'b000011;
   localparam logic [5:0] op_slt   = 6'b000100;
   localparam logic [5:0] op_mul   = 6'b000101;
   localparam logic [5:0] op_lw    = 6'b001000;
   localparam logic [5:0] op_sw    = 6'b001001;
   localparam logic [5:0] op_addi  = 6'b001010;
   localparam logic [5:0] op_subi  = 6'b001011;
   localparam logic [5:0] op_slti  = 6'b001100;
   localparam logic [5:0] op_bneqz = 6'b001101;
   localparam logic [5:0] op_beqz  = 6'b001110;
   localparam logic [5:0] op_hlt   = 6'b111111;
   localparam logic [5:0] op_nop   = 6'b111110;
   localparam logic [31:0] nop_ir  = {op_nop, 26'd0};

   logic [31:0] MEM [0:MEM_WORDS-1];
   logic [31:0] Register [0:31];
   logic [31:0] PC;
   logic        HALTED, BRANCH_TAKEN;

   logic [31:0] IF_ID_IR, IF_ID_NPC;
   logic [5:0]  ID_EX_OP;
   logic [4:0]  ID_EX_RS, ID_EX_RT, ID_EX_DST;
   logic        ID_EX_WR;
   logic [31:0] ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM;
   logic [5:0]  EX_MEM_OP;
   logic [4:0]  EX_MEM_DST;
   logic        EX_MEM_WR, EX_MEM_COND;
   logic [31:0] EX_MEM_ALUOUT, EX_MEM_B;
   logic [5:0]  MEM_WB_OP;
   logic [4:0]  MEM_WB_DST;
   logic        MEM_WB_WR;
   logic [31:0] MEM_WB_ALUOUT, MEM_WB_LMD;

   function automatic logic [AW-1:0] wrap(input logic [31:0] a);
      logic [31:0] m;
      m = a % MEM_WORDS;
      return m[AW-1:0];
   endfunction

   function automatic logic writes_reg(input logic [5:0] op);
      case (op)
         op_add, op_sub, op_and, op_or, op_slt,
         op_addi, op_subi, op_slti, op_lw: return 1'b1;
`ifdef MUL_EN
         op_mul: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // decode fields of the instruction sitting in IF/ID
   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd, id_dst;
   logic [31:0] id_imm, id_a, id_b, wb_val;
   logic        id_wr;

   assign id_op  = IF_ID_IR[31:26];
   assign id_rs  = IF_ID_IR[25:21];
   assign id_rt  = IF_ID_IR[20:16];
   assign id_rd  = IF_ID_IR[15:11];
   assign id_imm = {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};
   assign id_dst = (id_op <= op_mul) ? id_rd : id_rt;
   assign id_wr  = writes_reg(id_op) && (id_dst != 5'd0);
   assign wb_val = (MEM_WB_OP == op_lw) ? MEM_WB_LMD : MEM_WB_ALUOUT;

   // register read with write-through of the value retiring on this edge
   always_comb begin
      id_a = Register[id_rs];
      id_b = Register[id_rt];
      if (MEM_WB_WR && MEM_WB_DST == id_rs) id_a = wb_val;
      if (MEM_WB_WR && MEM_WB_DST == id_rt) id_b = wb_val;
      if (id_rs == 5'd0) id_a = '0;
      if (id_rt == 5'd0) id_b = '0;
   end

   // operand forwarding; a load in EX/MEM has no data yet, so it is skipped
   logic        exm_fwd;
   logic [31:0] ex_a, ex_b, ex_out;
   logic        ex_cond;

   assign exm_fwd = EX_MEM_WR && (EX_MEM_OP != op_lw);

   always_comb begin
      ex_a = ID_EX_A;
      ex_b = ID_EX_B;
      if (exm_fwd && EX_MEM_DST == ID_EX_RS)        ex_a = EX_MEM_ALUOUT;
      else if (MEM_WB_WR && MEM_WB_DST == ID_EX_RS) ex_a = wb_val;
      if (exm_fwd && EX_MEM_DST == ID_EX_RT)        ex_b = EX_MEM_ALUOUT;
      else if (MEM_WB_WR && MEM_WB_DST == ID_EX_RT) ex_b = wb_val;
   end

   always_comb begin
      ex_out  = '0;
      ex_cond = 1'b0;
      case (ID_EX_OP)
         op_add:  ex_out = ex_a + ex_b;
         op_sub:  ex_out = ex_a - ex_b;
         op_and:  ex_out = ex_a & ex_b;
         op_or:   ex_out = ex_a | ex_b;
         op_slt:  ex_out = {31'd0, $signed(ex_a) < $signed(ex_b)};
`ifdef MUL_EN
         op_mul:  ex_out = ex_a * ex_b;
`endif
         op_addi: ex_out = ex_a + ID_EX_IMM;
         op_subi: ex_out = ex_a - ID_EX_IMM;
         op_slti: ex_out = {31'd0, $signed(ex_a) < $signed(ID_EX_IMM)};
         op_lw, op_sw: ex_out = ex_a + ID_EX_IMM;
         op_bneqz: begin
            ex_out  = ID_EX_NPC + ID_EX_IMM;
            ex_cond = (ex_a != 32'd0);
         end
         op_beqz: begin
            ex_out  = ID_EX_NPC + ID_EX_IMM;
            ex_cond = (ex_a == 32'd0);
         end
         default: ;
      endcase
   end

   logic br_taken, halt_now, advance;
   assign br_taken = (EX_MEM_OP == op_bneqz || EX_MEM_OP == op_beqz) && EX_MEM_COND;
   assign halt_now = (MEM_WB_OP == op_hlt);
   assign advance  = !HALTED && !halt_now;
   assign halted   = HALTED;

   // architectural storage is never reset and freezes once HLT retires
   always_ff @(posedge clk1) begin
      if (!rst && advance) begin
         if (MEM_WB_WR) Register[MEM_WB_DST] <= wb_val;
         if (EX_MEM_OP == op_sw) MEM[wrap(EX_MEM_ALUOUT)] <= EX_MEM_B;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         PC            <= '0;
         HALTED        <= 1'b0;
         BRANCH_TAKEN  <= 1'b0;
         IF_ID_IR      <= nop_ir;
         IF_ID_NPC     <= '0;
         ID_EX_OP      <= op_nop;
         ID_EX_RS      <= '0;
         ID_EX_RT      <= '0;
         ID_EX_DST     <= '0;
         ID_EX_WR      <= 1'b0;
         ID_EX_NPC     <= '0;
         ID_EX_A       <= '0;
         ID_EX_B       <= '0;
         ID_EX_IMM     <= '0;
         EX_MEM_OP     <= op_nop;
         EX_MEM_DST    <= '0;
         EX_MEM_WR     <= 1'b0;
         EX_MEM_COND   <= 1'b0;
         EX_MEM_ALUOUT <= '0;
         EX_MEM_B      <= '0;
         MEM_WB_OP     <= op_nop;
         MEM_WB_DST    <= '0;
         MEM_WB_WR     <= 1'b0;
         MEM_WB_ALUOUT <= '0;
         MEM_WB_LMD    <= '0;
      end else if (!advance) begin
         HALTED <= 1'b1;
      end else begin
         MEM_WB_OP     <= EX_MEM_OP;
         MEM_WB_DST    <= EX_MEM_DST;
         MEM_WB_WR     <= EX_MEM_WR;
         MEM_WB_ALUOUT <= EX_MEM_ALUOUT;
         MEM_WB_LMD    <= MEM[wrap(EX_MEM_ALUOUT)];
         // a taken branch squashes every younger instruction, including the one in EX
         EX_MEM_OP     <= br_taken ? op_nop : ID_EX_OP;
         EX_MEM_DST    <= ID_EX_DST;
         EX_MEM_WR     <= br_taken ? 1'b0 : ID_EX_WR;
         EX_MEM_COND   <= br_taken ? 1'b0 : ex_cond;
         EX_MEM_ALUOUT <= ex_out;
         EX_MEM_B      <= ex_b;
         ID_EX_OP      <= br_taken ? op_nop : id_op;
         ID_EX_WR      <= br_taken ? 1'b0 : id_wr;
         ID_EX_RS      <= id_rs;
         ID_EX_RT      <= id_rt;
         ID_EX_DST     <= id_dst;
         ID_EX_NPC     <= IF_ID_NPC;
         ID_EX_A       <= id_a;
         ID_EX_B       <= id_b;
         ID_EX_IMM     <= id_imm;
         IF_ID_IR      <= br_taken ? nop_ir : MEM[wrap(PC)];
         IF_ID_NPC     <= PC + 32'd1;
         PC            <= br_taken ? EX_MEM_ALUOUT : PC + 32'd1;
         BRANCH_TAKEN  <= br_taken;
      end
   end
endmodule

// File: tb/tb_pipelined_mips32.sv
// Bench for pipelined_mips32: an instruction-level interpreter predicts final registers,
// memory and taken-branch count; a per-cycle monitor checks halt freeze and branch pulses.
module tb_pipelined_mips32;
   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   logic halted;

   pipelined_mips32 #(.MEM_WORDS(1024)) dut (.clk1(clk1), .rst(rst), .halted(halted));

   always #5 clk1 = ~clk1;

`ifdef MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   int passed = 0;
   int total  = 0;

   logic [31:0] mmem [0:1023];
   logic [31:0] mreg [0:31];
   logic [31:0] prog [$];

   bit          mon_on = 1'b0;
   bit          halt_seen;
   bit          bt_prev;
   int          bt_pulses;
   logic [31:0] halt_pc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, act, act, exp, exp);
   endtask

   function automatic logic [31:0] rt_(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] it_(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   localparam logic [31:0] HLT = 32'hFC00_0000;

   task automatic mw(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) mreg[r] = v;
   endtask

   // sequential ISA semantics: no delay slot, wrap-around memory indexing
   task automatic model_run(output int taken);
      logic [31:0] pc, ir, a, b, imm;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      bit          done;
      taken = 0; pc = 0; done = 1'b0;
      for (int n = 0; n < 5000 && !done; n++) begin
         ir  = mmem[pc % 1024];
         op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
         imm = {{16{ir[15]}}, ir[15:0]};
         a   = (rs == 0) ? 32'd0 : mreg[rs];
         b   = (rt == 0) ? 32'd0 : mreg[rt];
         pc  = pc + 1;
         case (op)
            6'b000000: mw(rd, a + b);
            6'b000001: mw(rd, a - b);
            6'b000010: mw(rd, a & b);
            6'b000011: mw(rd, a | b);
            6'b000100: mw(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'b000101: if (MUL_ON) mw(rd, a * b);
            6'b001010: mw(rt, a + imm);
            6'b001011: mw(rt, a - imm);
            6'b001100: mw(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
            6'b001000: mw(rt, mmem[(a + imm) % 1024]);
            6'b001001: mmem[(a + imm) % 1024] = b;
            6'b001101: if (a != 0) begin pc = pc + imm; taken++; end
            6'b001110: if (a == 0) begin pc = pc + imm; taken++; end
            6'b111111: done = 1'b1;
            default: ;
         endcase
      end
   endtask

   // per-cycle monitor: halt is sticky with PC frozen; BRANCH_TAKEN is a single-cycle pulse
   always @(negedge clk1) begin
      if (mon_on) begin
         if (halt_seen) begin
            chk("halted sticky", {31'd0, halted}, 32'd1);
            chk("PC frozen after halt", dut.PC, halt_pc);
         end else if (halted) begin
            halt_seen = 1'b1;
            halt_pc   = dut.PC;
         end
         if (dut.BRANCH_TAKEN) begin
            bt_pulses++;
            chk("BRANCH_TAKEN one cycle", {31'd0, bt_prev}, 32'd0);
         end
         bt_prev = dut.BRANCH_TAKEN;
      end
   end

   int last_taken;

   task automatic run_test(input string name, input int daddr, input logic [31:0] dval, input int budget);
      int cyc, bad, first_bad;
      @(negedge clk1);
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) begin dut.MEM[i] = 32'd0; mmem[i] = 32'd0; end
      for (int i = 0; i < 32; i++) begin dut.Register[i] = 32'd0; mreg[i] = 32'd0; end
      foreach (prog[i]) begin dut.MEM[i] = prog[i]; mmem[i] = prog[i]; end
      if (daddr >= 0) begin dut.MEM[daddr] = dval; mmem[daddr] = dval; end
      @(negedge clk1);
      @(negedge clk1);
      chk({name, " reset PC"}, dut.PC, 32'd0);
      chk({name, " reset HALTED"}, {31'd0, dut.HALTED}, 32'd0);
      chk({name, " reset BRANCH_TAKEN"}, {31'd0, dut.BRANCH_TAKEN}, 32'd0);
      chk({name, " reset halted"}, {31'd0, halted}, 32'd0);
      model_run(last_taken);
      halt_seen = 1'b0; bt_prev = 1'b0; bt_pulses = 0; halt_pc = '0;
      rst = 1'b0;
      mon_on = 1'b1;
      cyc = 0;
      while (!halted && cyc < budget) begin
         @(negedge clk1);
         cyc++;
      end
      chk({name, " halted within budget"}, {31'd0, halted}, 32'd1);
      repeat (6) @(negedge clk1);
      mon_on = 1'b0;
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s R%0d", name, r), dut.Register[r], mreg[r]);
      bad = 0; first_bad = -1;
      for (int i = 0; i < 1024; i++)
         if (dut.MEM[i] !== mmem[i]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      if (bad != 0) $display("%s memory differs first at word %0d", name, first_bad);
      chk({name, " memory words differing"}, 32'(bad), 32'd0);
      chk({name, " taken-branch pulses"}, 32'(bt_pulses), 32'(last_taken));
   endtask

   initial begin
      // back-to-back forwarding
      prog = '{it_(6'b001010, 1, 0, 10), it_(6'b001010, 2, 0, 20),
               rt_(6'b000000, 3, 1, 2), rt_(6'b000001, 4, 3, 1), HLT};
      run_test("fwd", -1, 32'd0, 60);
      chk("fwd model R3", mreg[3], 32'd30);
      chk("fwd model R4", mreg[4], 32'd20);

      // load / store with one filler after the load
      prog = '{it_(6'b001010, 1, 0, 120), it_(6'b001000, 2, 1, 0), rt_(6'b000011, 9, 9, 9),
               it_(6'b001010, 2, 2, 45), it_(6'b001001, 2, 1, 1), HLT};
      run_test("ldst", 120, 32'd85, 60);
      chk("ldst model MEM[121]", mmem[121], 32'd130);

      // factorial loop
      prog = '{it_(6'b001010, 10, 0, 200), it_(6'b001010, 2, 0, 1), rt_(6'b000011, 9, 9, 9),
               it_(6'b001000, 3, 10, 0), rt_(6'b000011, 9, 9, 9), rt_(6'b000101, 2, 2, 3),
               it_(6'b001011, 3, 3, 1), rt_(6'b000011, 9, 9, 9), it_(6'b001101, 0, 3, -4),
               it_(6'b001001, 2, 10, -2), HLT};
      run_test("fact", 200, 32'd7, 100);
      chk("fact model MEM[198]", mmem[198], MUL_ON ? 32'd5040 : 32'd1);
      chk("fact model taken", 32'(last_taken), 32'd6);

      // taken branch squashes the two skipped instructions and the slot behind it
      prog = '{it_(6'b001010, 1, 0, 0), it_(6'b001110, 0, 1, 2), it_(6'b001010, 5, 0, 9),
               it_(6'b001010, 6, 0, 9), it_(6'b001010, 7, 0, 3), HLT};
      run_test("branch", -1, 32'd0, 60);
      chk("branch model R5", mreg[5], 32'd0);
      chk("branch model R6", mreg[6], 32'd0);
      chk("branch model R7", mreg[7], 32'd3);
      chk("branch model taken", 32'(last_taken), 32'd1);

      // R0 is hard-wired; nothing after HLT commits
      prog = '{it_(6'b001010, 0, 0, 5), HLT, it_(6'b001010, 8, 0, 1)};
      run_test("r0halt", -1, 32'd0, 60);
      chk("r0halt model R0", mreg[0], 32'd0);
      chk("r0halt model R8", mreg[8], 32'd0);

      // SLT/SLTI signedness, AND, and MUL (NOP when not built in)
      prog = '{it_(6'b001010, 1, 0, 6), it_(6'b001010, 2, 0, 7), it_(6'b001010, 3, 0, 99),
               it_(6'b001010, 4, 0, -3), rt_(6'b000101, 3, 1, 2), rt_(6'b000100, 5, 4, 1),
               it_(6'b001100, 6, 1, -1), rt_(6'b000010, 7, 1, 2), HLT};
      run_test("alu", -1, 32'd0, 60);
      chk("alu model R3", mreg[3], MUL_ON ? 32'd42 : 32'd99);
      chk("alu model R5", mreg[5], 32'd1);
      chk("alu model R6", mreg[6], 32'd0);
      chk("alu model R7", mreg[7], 32'd6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
